// File: rtl/dct_stream_checker_if.sv
// Stream/bus bundle between a DCT row source, a golden row memory and the
// dct_stream_checker. The checker is the slave; the environment is the master.
interface dct_stream_checker_if #(
    parameter int LANES = 16,
    parameter int W     = 12,
    parameter int AW    = 9,
    parameter int CNT_W = 16
);
    logic                 start;
    logic [AW:0]          num_rows;
    logic                 dut_valid;
    logic [LANES*W-1:0]   dut_data;
    logic [AW-1:0]        exp_rd_addr;
    logic [LANES*W-1:0]   exp_rd_data;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [AW:0]          row_cnt;
    logic [CNT_W-1:0]     err_rows;
    logic [LANES-1:0]     err_lanes;
    logic                 first_err_valid;
    logic [AW-1:0]        first_err_idx;

    modport master (
        output start, num_rows, dut_valid, dut_data, exp_rd_data,
        input  exp_rd_addr, busy, done, pass, row_cnt, err_rows, err_lanes,
               first_err_valid, first_err_idx
    );

    modport slave (
        input  start, num_rows, dut_valid, dut_data, exp_rd_data,
        output exp_rd_addr, busy, done, pass, row_cnt, err_rows, err_lanes,
               first_err_valid, first_err_idx
    );
endinterface

// File: rtl/dct_stream_checker.sv
// Compares LANES-wide DCT coefficient rows against golden rows read from a
// synchronous memory, with per-lane tolerance and run-level error statistics.
module dct_stream_checker #(
    parameter int LANES = 16,
    parameter int W     = 12,
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int TOL   = 0,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dct_stream_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
    localparam logic [W:0]  TOL_V   = TOL[W:0];
    localparam logic [AW:0] ONE_V   = {{AW{1'b0}}, 1'b1};

    state_t             state_r;
    logic [AW:0]        target_r;
    logic [AW:0]        row_cnt_r;
    logic [CNT_W-1:0]   err_rows_r;
    logic [LANES-1:0]   err_lanes_r;
    logic               first_err_valid_r;
    logic [AW-1:0]      first_err_idx_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;

    logic               accept_s;
    logic [LANES-1:0]   fail_s;
    logic               any_fail_s;
    logic [AW:0]        row_nxt_s;
    logic [AW:0]        num_clamped_s;
    logic               last_row_s;
    logic               err_sat_s;
    logic [AW-1:0]      rd_addr_s;

    // Difference is taken in W+1 bits so full-scale opposite extremes cannot wrap.
    function automatic logic lane_fail(input logic [W-1:0] dut_v, input logic [W-1:0] exp_v);
        logic signed [W:0] diff;
        logic        [W:0] mag;
        diff = $signed({dut_v[W-1], dut_v}) - $signed({exp_v[W-1], exp_v});
        if (diff[W]) begin
            mag = $unsigned(-diff);
        end else begin
            mag = $unsigned(diff);
        end
        return (mag > TOL_V);
    endfunction

    // Per-lane tolerance check of the current DUT row against the golden row.
    always_comb begin
        fail_s = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            fail_s[k] = lane_fail(bus.dut_data[k*W +: W], bus.exp_rd_data[k*W +: W]);
        end
        any_fail_s = |fail_s;
    end

    // Run bookkeeping helpers: acceptance, clamp, last-row and saturation.
    always_comb begin
        accept_s  = (state_r == ST_CHECK) && bus.dut_valid;
        row_nxt_s = row_cnt_r + ONE_V;
        if (bus.num_rows > DEPTH_V) begin
            num_clamped_s = DEPTH_V;
        end else begin
            num_clamped_s = bus.num_rows;
        end
        last_row_s = (row_cnt_r == (target_r - ONE_V));
        err_sat_s  = &err_rows_r;
    end

    // Prefetch address: the next row is requested on the cycle a row is accepted,
    // so the synchronous memory always presents the row for row_cnt in CHECK.
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        case (state_r)
            ST_CHECK: begin
                if (bus.dut_valid) begin
                    rd_addr_s = row_nxt_s[AW-1:0];
                end else begin
                    rd_addr_s = row_cnt_r[AW-1:0];
                end
            end
            default: rd_addr_s = {AW{1'b0}};
        endcase
    end

    // Control FSM with registered status outputs and error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            target_r          <= {(AW+1){1'b0}};
            row_cnt_r         <= {(AW+1){1'b0}};
            err_rows_r        <= {CNT_W{1'b0}};
            err_lanes_r       <= {LANES{1'b0}};
            first_err_valid_r <= 1'b0;
            first_err_idx_r   <= {AW{1'b0}};
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            pass_r            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        target_r          <= num_clamped_s;
                        row_cnt_r         <= {(AW+1){1'b0}};
                        err_rows_r        <= {CNT_W{1'b0}};
                        err_lanes_r       <= {LANES{1'b0}};
                        first_err_valid_r <= 1'b0;
                        first_err_idx_r   <= {AW{1'b0}};
                        if (num_clamped_s == {(AW+1){1'b0}}) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= 1'b1;
                        end else begin
                            state_r <= ST_CHECK;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                            pass_r  <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept_s) begin
                        row_cnt_r   <= row_nxt_s;
                        err_lanes_r <= err_lanes_r | fail_s;
                        if (any_fail_s) begin
                            if (!err_sat_s) begin
                                err_rows_r <= err_rows_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                            if (!first_err_valid_r) begin
                                first_err_valid_r <= 1'b1;
                                first_err_idx_r   <= row_cnt_r[AW-1:0];
                            end
                        end
                        if (last_row_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_rows_r == {CNT_W{1'b0}}) && !any_fail_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.exp_rd_addr     = rd_addr_s;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.pass            = pass_r;
    assign bus.row_cnt         = row_cnt_r;
    assign bus.err_rows        = err_rows_r;
    assign bus.err_lanes       = err_lanes_r;
    assign bus.first_err_valid = first_err_valid_r;
    assign bus.first_err_idx   = first_err_idx_r;

endmodule

// File: tb/tb_dct_stream_checker.sv
// Directed bench: two checker builds (exact/16-bit counter and TOL=1/2-bit
// counter) see the same stream, each backed by its own golden memory model.
module tb_dct_stream_checker;
    localparam int LANES = 16;
    localparam int W     = 12;
    localparam int AW    = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW:0]       num_rows;
    logic              dut_valid;
    int                dut_row;
    int                mode;
    int                checks   = 0;
    int                failures = 0;

    dct_stream_checker_if #(.LANES(LANES), .W(W), .AW(AW), .CNT_W(16)) b0 ();
    dct_stream_checker_if #(.LANES(LANES), .W(W), .AW(AW), .CNT_W(2))  b1 ();

    dct_stream_checker #(.LANES(LANES), .W(W), .DEPTH(512), .AW(AW), .TOL(0), .CNT_W(16))
        u_exact (.clk(clk), .rst(rst), .bus(b0.slave));
    dct_stream_checker #(.LANES(LANES), .W(W), .DEPTH(512), .AW(AW), .TOL(1), .CNT_W(2))
        u_tol (.clk(clk), .rst(rst), .bus(b1.slave));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gold_lane(input int r, input int l);
        int t;
        if (r == 300 && (l == 0 || l == 15)) return 12'h800;
        t = r*37 + l*113 + r*l*7;
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] dut_lane(input int r, input int l, input int m);
        logic [W-1:0] v;
        v = gold_lane(r, l);
        case (m)
            1: begin
                if (r == 5 && l == 9) v = v + 12'd1;
                if (r == 300 && (l == 0 || l == 15)) v = 12'h7FF;
            end
            2: begin
                if (r == 7 && l == 3) v = v + 12'd1;
                if (r == 8 && l == 4) v = v - 12'd2;
            end
            3: if (l == 2) v = v + 12'd5;
            4: if (r >= 10 && r <= 14 && l == 1) v = v + 12'd3;
            default: v = v;
        endcase
        return v;
    endfunction

    function automatic logic [LANES*W-1:0] gold_row(input int r);
        logic [LANES*W-1:0] d;
        for (int l = 0; l < LANES; l++) d[l*W +: W] = gold_lane(r, l);
        return d;
    endfunction

    function automatic logic [LANES*W-1:0] dut_row_data(input int r, input int m);
        logic [LANES*W-1:0] d;
        for (int l = 0; l < LANES; l++) d[l*W +: W] = dut_lane(r, l, m);
        return d;
    endfunction

    assign b0.start     = start;
    assign b1.start     = start;
    assign b0.num_rows  = num_rows;
    assign b1.num_rows  = num_rows;
    assign b0.dut_valid = dut_valid;
    assign b1.dut_valid = dut_valid;
    assign b0.dut_data  = dut_row_data(dut_row, mode);
    assign b1.dut_data  = dut_row_data(dut_row, mode);

    always @(posedge clk) begin
        b0.exp_rd_data <= gold_row(int'(b0.exp_rd_addr));
        b1.exp_rd_data <= gold_row(int'(b1.exp_rd_addr));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_rows = n[AW:0];
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Feeds n rows beginning at row 'base'; optional random gaps, a stray start
    // pulse mid-run, and a per-cycle prefetch-address check.
    task automatic feed(input int n, input int base, input bit gaps, input bit chk_addr);
        int r = 0;
        int guard = 0;
        while (r < n && guard < 4000) begin
            dut_valid = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
            dut_row   = base + r;
            start     = gaps && (r == 20);
            #1;
            if (chk_addr)
                chk("rd_addr", b0.exp_rd_addr, dut_valid ? (base + r + 1) % 512 : base + r);
            @(posedge clk); #1;
            if (dut_valid) r++;
            guard++;
        end
        dut_valid = 1'b0;
        start     = 1'b0;
        chk("feed_rows", r, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int fed;
        rst = 1'b1; start = 1'b0; num_rows = '0; dut_valid = 1'b0; dut_row = 0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", b0.busy, 0);
        chk("rst_done", b0.done, 0);
        chk("rst_pass", b0.pass, 0);
        chk("rst_row_cnt", b0.row_cnt, 0);
        chk("rst_addr", b0.exp_rd_addr, 0);

        // Clean full run: done exactly 512 edges after the start edge.
        mode = 0;
        do_start(512);
        chk("clean_busy", b0.busy, 1);
        feed(511, 0, 1'b0, 1'b0);
        chk("clean_done_early", b0.done, 0);
        feed(1, 511, 1'b0, 1'b0);
        chk("clean_done", b0.done, 1);
        chk("clean_pass", b0.pass, 1);
        chk("clean_err_rows", b0.err_rows, 0);
        chk("clean_err_lanes", b0.err_lanes, 0);
        chk("clean_row_cnt", b0.row_cnt, 512);

        // Row 5 lane 9 +1 and row 300 lanes 0/15 at +max versus golden -max.
        mode = 1;
        do_start(512);
        feed(512, 0, 1'b0, 1'b0);
        chk("m1_done", b0.done, 1);
        chk("m1_err_rows", b0.err_rows, 2);
        chk("m1_err_lanes", b0.err_lanes, 16'h8201);
        chk("m1_first_valid", b0.first_err_valid, 1);
        chk("m1_first_idx", b0.first_err_idx, 5);
        chk("m1_pass", b0.pass, 0);
        chk("m1_tol_err_rows", b1.err_rows, 1);

        // Tolerance: +1 on row 7 is within TOL=1, -2 on row 8 is not.
        mode = 2;
        do_start(16);
        feed(16, 0, 1'b0, 1'b0);
        chk("tol_err_rows", b1.err_rows, 1);
        chk("tol_first_idx", b1.first_err_idx, 8);
        chk("tol_err_lanes", b1.err_lanes, 16'h0010);
        chk("exact_err_rows", b0.err_rows, 2);
        chk("exact_first_idx", b0.first_err_idx, 7);
        chk("exact_err_lanes", b0.err_lanes, 16'h0018);

        // Zero-row run from DONE: immediate done with everything cleared.
        mode = 0;
        do_start(0);
        chk("zero_done", b0.done, 1);
        chk("zero_pass", b0.pass, 1);
        chk("zero_busy", b0.busy, 0);
        chk("zero_err_rows", b0.err_rows, 0);
        chk("zero_first_valid", b0.first_err_valid, 0);
        chk("zero_addr", b0.exp_rd_addr, 0);

        // Oversized request is clamped to 512 rows.
        do_start(600);
        fed = 0;
        while (!b0.done && fed < 700) begin
            dut_valid = 1'b1;
            dut_row   = fed;
            @(posedge clk); #1;
            fed++;
        end
        dut_valid = 1'b0;
        chk("clamp_rows_fed", fed, 512);
        chk("clamp_row_cnt", b0.row_cnt, 512);
        chk("clamp_pass", b0.pass, 1);

        // Random gaps, stray start mid-run, address tracked every cycle.
        do_start(64);
        feed(64, 0, 1'b1, 1'b1);
        chk("gap_done", b0.done, 1);
        chk("gap_pass", b0.pass, 1);
        chk("gap_row_cnt", b0.row_cnt, 64);
        dut_valid = 1'b1;
        dut_row   = 0;
        repeat (3) @(posedge clk);
        #1;
        dut_valid = 1'b0;
        chk("idle_valid_row_cnt", b0.row_cnt, 64);
        chk("idle_valid_addr", b0.exp_rd_addr, 0);

        // Saturation of the 2-bit counter with five bad rows.
        mode = 4;
        do_start(20);
        feed(20, 0, 1'b0, 1'b0);
        chk("sat_err_rows", b1.err_rows, 3);
        chk("sat_first_idx", b1.first_err_idx, 10);
        chk("sat_exact_err_rows", b0.err_rows, 5);

        // Abort a failing run with reset at row 100, then a clean run.
        mode = 3;
        do_start(200);
        feed(100, 0, 1'b0, 1'b0);
        chk("abort_err_rows", b0.err_rows, 100);
        chk("abort_busy", b0.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy_rst", b0.busy, 0);
        chk("abort_row_cnt", b0.row_cnt, 0);
        chk("abort_err_rows_rst", b0.err_rows, 0);
        chk("abort_err_lanes", b0.err_lanes, 0);
        chk("abort_first_valid", b0.first_err_valid, 0);
        chk("abort_first_idx", b0.first_err_idx, 0);
        chk("abort_done", b0.done, 0);
        chk("abort_tol_err_rows", b1.err_rows, 0);
        mode = 0;
        do_start(32);
        feed(32, 0, 1'b0, 1'b0);
        chk("rerun_done", b0.done, 1);
        chk("rerun_pass", b0.pass, 1);
        chk("rerun_row_cnt", b0.row_cnt, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
